// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with inhibit/RTS, ACK check and timeout.
// Define PS2_TX_RESEND_EN to retransmit a failed byte up to two more times before reporting.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2400,
  parameter int TIMEOUT_CYCLES = 360000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o,
  output logic       rx_inhibit_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       timeout_o
);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE} state_t;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  logic [1:0] clk_sync, dat_sync;
  logic [FW-1:0] clk_cnt, dat_cnt;
  logic clk_f, dat_f, clk_f_d;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic [7:0] data;
  logic parity;
  logic [3:0] bit_cnt;
  logic fall, tmo, fail, retry;
`ifdef PS2_TX_RESEND_EN
  logic [1:0] retries;
  assign retry = retries != 2'd2;
`else
  assign retry = 1'b0;
`endif
  assign tx_ready_o = state == IDLE;
  assign rx_inhibit_o = state != IDLE;
  assign fall = clk_f_d & ~clk_f;
  assign tmo = (state inside {RTS, SHIFT, ACK, WAIT_IDLE}) && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign fail = tmo || (state == ACK && fall && dat_f);
  // A new level is accepted only after FILTER_LEN consecutive samples disagree with the current one
  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_cnt <= '0;
      dat_cnt <= '0;
      clk_f <= 1'b1;
      dat_f <= 1'b1;
      clk_f_d <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_i};
      dat_sync <= {dat_sync[0], ps2_dat_i};
      clk_f_d <= clk_f;
      if (clk_sync[1] == clk_f) clk_cnt <= '0;
      else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f <= clk_sync[1];
        clk_cnt <= '0;
      end else clk_cnt <= clk_cnt + FW'(1);
      if (dat_sync[1] == dat_f) dat_cnt <= '0;
      else if (dat_cnt == FW'(FILTER_LEN - 1)) begin
        dat_f <= dat_sync[1];
        dat_cnt <= '0;
      end else dat_cnt <= dat_cnt + FW'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      state <= IDLE;
      ps2_clk_oe_o <= 1'b0;
      ps2_dat_oe_o <= 1'b0;
      done_o <= 1'b0;
      ack_err_o <= 1'b0;
      timeout_o <= 1'b0;
      icnt <= '0;
      tcnt <= '0;
      data <= '0;
      parity <= 1'b0;
      bit_cnt <= '0;
`ifdef PS2_TX_RESEND_EN
      retries <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      ack_err_o <= 1'b0;
      timeout_o <= 1'b0;
      tcnt <= (fall || state == IDLE || state == INHIBIT) ? '0 : tcnt + TW'(1);
      if (fail) begin
        ps2_dat_oe_o <= 1'b0;
        ps2_clk_oe_o <= retry;
        bit_cnt <= '0;
        icnt <= '0;
        state <= retry ? INHIBIT : IDLE;
        timeout_o <= !retry && tmo;
        ack_err_o <= !retry && !tmo;
`ifdef PS2_TX_RESEND_EN
        if (retry) retries <= retries + 2'd1;
`endif
      end else begin
        case (state)
          IDLE: if (tx_valid_i) begin
            data <= tx_data_i;
            parity <= ~^tx_data_i;
            bit_cnt <= '0;
            icnt <= '0;
            ps2_clk_oe_o <= 1'b1;
            state <= INHIBIT;
`ifdef PS2_TX_RESEND_EN
            retries <= '0;
`endif
          end
          INHIBIT: begin
            icnt <= icnt + IW'(1);
            if (icnt == IW'(INHIBIT_CYCLES - 2)) ps2_dat_oe_o <= 1'b1;
            if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
              ps2_clk_oe_o <= 1'b0;
              state <= RTS;
            end
          end
          RTS: state <= SHIFT;
          // Host changes data on the device's falling edge; device samples on the rising edge
          SHIFT: if (fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            ps2_dat_oe_o <= bit_cnt < 4'd8 ? ~data[bit_cnt[2:0]] : bit_cnt == 4'd8 ? ~parity : 1'b0;
            if (bit_cnt == 4'd9) state <= ACK;
          end
          ACK: if (fall) state <= WAIT_IDLE;
          WAIT_IDLE: if (clk_f && dat_f) begin
            done_o <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a behavioural PS/2 keyboard model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INHIBIT = 20, TIMEOUT = 500, FILT = 2, HALF = 30;
`ifdef PS2_TX_RESEND_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif
  // 2 sync stages, edge register and the drive-after-edge offset between device fall and timeout
  localparam int TO_LAT = TIMEOUT + FILT + 3;
  logic clk = 1'b0, res_n = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, clk_oe, dat_oe, rx_inhibit, done, ack_err, timeout;
  logic dev_clk = 1'b1, dev_dat = 1'b1, ps2_clk, ps2_dat;
  assign ps2_clk = dev_clk & ~clk_oe;
  assign ps2_dat = dev_dat & ~dat_oe;
  int checks = 0, errors = 0, cyc = 0;
  int done_cnt = 0, ae_cnt = 0, to_cnt = 0, acc_cnt = 0;
  int done_cyc = 0, acc_cyc = 0, to_cyc = 0, last_fall_cyc = 0;
  int run = 0, inh_len = 0, inh_cnt = 0, inh_seen = 0, overlap = 0, idle_drive = 0;
  logic first_dat = 1'b0, last_dat = 1'b0, inh_first = 1'b0, inh_last = 1'b0, ae_ready = 1'b0;
  logic [1:0] ae_oe = 2'b00, to_oe = 2'b00;
  logic [7:0] exp_q[$];

  ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT), .FILTER_LEN(FILT)) dut (
    .clk_i(clk), .res_n_i(res_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat), .ps2_clk_oe_o(clk_oe), .ps2_dat_oe_o(dat_oe),
    .rx_inhibit_o(rx_inhibit), .done_o(done), .ack_err_o(ack_err), .timeout_o(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (ack_err) begin
      ae_cnt <= ae_cnt + 1;
      ae_ready <= tx_ready;
      ae_oe <= {clk_oe, dat_oe};
    end
    if (timeout) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
      to_oe <= {clk_oe, dat_oe};
    end
    if ((done & ack_err) | (done & timeout) | (ack_err & timeout)) overlap <= overlap + 1;
    if (tx_ready && (clk_oe || dat_oe)) idle_drive <= idle_drive + 1;
    if (tx_valid && tx_ready && res_n) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
    if (clk_oe) begin
      run <= run + 1;
      if (run == 0) first_dat <= dat_oe;
      last_dat <= dat_oe;
    end else if (run != 0) begin
      inh_len <= run;
      inh_first <= first_dat;
      inh_last <= last_dat;
      inh_cnt <= inh_cnt + 1;
      run <= 0;
    end
  end

  task automatic wcyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int copies);
    tx_data = b;
    tx_valid = 1'b1;
    for (int i = 0; i < copies; i++) exp_q.push_back(b);
    wcyc(1);
    tx_valid = 1'b0;
  endtask

  // Keyboard model: waits for the inhibit/release, then clocks nclk falling edges
  task automatic dev_frame(input int nclk, input bit ack, input bit score);
    logic [10:0] bits, want;
    logic [7:0] b;
    int n;
    bits = '0;
    n = 0;
    while (inh_cnt == inh_seen && n < 3000) begin
      wcyc(1);
      n++;
    end
    checks++;
    if (inh_cnt == inh_seen) begin
      errors++;
      $display("FAIL rts_wait: no inhibit release after %0d cycles", n);
      return;
    end
    inh_seen = inh_cnt;
    checks++;
    if (inh_len != INHIBIT || inh_first !== 1'b0 || inh_last !== 1'b1) begin
      errors++;
      $display("FAIL inhibit: len %0d first_dat_oe %b last_dat_oe %b, want %0d 0 1", inh_len, inh_first, inh_last, INHIBIT);
    end
    wcyc(10);
    bits[0] = ps2_dat;
    for (int k = 1; k <= nclk; k++) begin
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      wcyc(HALF);
      if (k <= 10) bits[k] = ps2_dat;
      dev_clk = 1'b1;
      if (k == 10 && ack) begin
        wcyc(HALF / 2);
        dev_dat = 1'b0;
        wcyc(HALF - HALF / 2);
      end else if (k < nclk) wcyc(HALF);
    end
    dev_dat = 1'b1;
    if (score) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame: got %b with no byte expected", bits);
      end else begin
        b = exp_q.pop_front();
        want = {1'b1, ~^b, b, 1'b0};
        if (bits !== want) begin
          errors++;
          $display("FAIL frame %h: got %b want %b (stop,par,d7..d0,start)", b, bits, want);
        end
      end
    end
  endtask

  task automatic test_reset;
    res_n = 1'b0;
    wcyc(3);
    checks++;
    if ({tx_ready, clk_oe, dat_oe, rx_inhibit, done, ack_err, timeout} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset: rdy,cko,dto,inh,done,aerr,to = %b want 1000000",
               {tx_ready, clk_oe, dat_oe, rx_inhibit, done, ack_err, timeout});
    end
    res_n = 1'b1;
    wcyc(5);
  endtask

  task automatic test_send(input logic [7:0] b);
    int d0, a0, t0, n;
    d0 = done_cnt; a0 = ae_cnt; t0 = to_cnt;
    send(b, 1);
    checks++;
    if (tx_ready !== 1'b0 || rx_inhibit !== 1'b1) begin
      errors++;
      $display("FAIL busy %h: tx_ready %b rx_inhibit %b want 0 1", b, tx_ready, rx_inhibit);
    end
    dev_frame(11, 1'b1, 1'b1);
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      wcyc(1);
      n++;
    end
    wcyc(3);
    checks++;
    if (done_cnt != d0 + 1 || ae_cnt != a0 || to_cnt != t0) begin
      errors++;
      $display("FAIL done %h: done/aerr/to deltas %0d %0d %0d want 1 0 0", b, done_cnt - d0, ae_cnt - a0, to_cnt - t0);
    end
  endtask

  task automatic test_ack_err;
    int d0, a0, n;
    d0 = done_cnt; a0 = ae_cnt;
    send(8'h3C, ATTEMPTS);
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_frame(11, 1'b0, 1'b1);
      if (a < ATTEMPTS - 1) begin
        checks++;
        if (ae_cnt != a0) begin
          errors++;
          $display("FAIL ack_err_early: pulse after attempt %0d", a + 1);
        end
      end
    end
    n = 0;
    while (ae_cnt == a0 && n < 200) begin
      wcyc(1);
      n++;
    end
    checks++;
    if (ae_cnt != a0 + 1 || done_cnt != d0 || ae_ready !== 1'b1 || ae_oe !== 2'b00) begin
      errors++;
      $display("FAIL ack_err: pulses %0d done %0d ready %b oe %b want 1 0 1 00", ae_cnt - a0, done_cnt - d0, ae_ready, ae_oe);
    end
    checks++;
    if (tx_ready !== 1'b1 || clk_oe !== 1'b0 || dat_oe !== 1'b0) begin
      errors++;
      $display("FAIL ack_err_idle: ready %b cko %b dto %b want 1 0 0", tx_ready, clk_oe, dat_oe);
    end
  endtask

  task automatic test_timeout;
    int d0, a0, t0, n;
    d0 = done_cnt; a0 = ae_cnt; t0 = to_cnt;
    send(8'hA5, 0);
    for (int a = 0; a < ATTEMPTS; a++) dev_frame(4, 1'b1, 1'b0);
    n = 0;
    while (to_cnt == t0 && n < 1500) begin
      wcyc(1);
      n++;
    end
    checks++;
    if (to_cnt != t0 + 1 || done_cnt != d0 || ae_cnt != a0 || to_oe !== 2'b00) begin
      errors++;
      $display("FAIL timeout: pulses %0d done %0d aerr %0d oe %b want 1 0 0 00", to_cnt - t0, done_cnt - d0, ae_cnt - a0, to_oe);
    end
    checks++;
    if (to_cyc - last_fall_cyc != TO_LAT) begin
      errors++;
      $display("FAIL timeout_delay: %0d cycles after device fall, want %0d", to_cyc - last_fall_cyc, TO_LAT);
    end
  endtask

  task automatic test_reset_mid;
    int d0, a0, t0;
    d0 = done_cnt; a0 = ae_cnt; t0 = to_cnt;
    send(8'h52, 0);
    dev_frame(4, 1'b1, 1'b0);
    checks++;
    if (dat_oe !== 1'b1) begin
      errors++;
      $display("FAIL shift_bit3: dat_oe %b want 1", dat_oe);
    end
    res_n = 1'b0;
    wcyc(1);
    checks++;
    if ({clk_oe, dat_oe, tx_ready, rx_inhibit} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_mid: cko,dto,rdy,inh = %b want 0010", {clk_oe, dat_oe, tx_ready, rx_inhibit});
    end
    wcyc(2);
    res_n = 1'b1;
    wcyc(TIMEOUT + 100);
    checks++;
    if (done_cnt != d0 || ae_cnt != a0 || to_cnt != t0) begin
      errors++;
      $display("FAIL reset_mid_pulse: done/aerr/to deltas %0d %0d %0d want 0 0 0", done_cnt - d0, ae_cnt - a0, to_cnt - t0);
    end
  endtask

  task automatic test_back_to_back;
    int d0, c0, n;
    d0 = done_cnt; c0 = acc_cnt;
    send(8'hF4, 1);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    dev_frame(11, 1'b1, 1'b1);
    n = 0;
    while (acc_cnt < c0 + 2 && n < 200) begin
      wcyc(1);
      n++;
    end
    tx_valid = 1'b0;
    exp_q.push_back(8'hFF);
    checks++;
    if (acc_cnt != c0 + 2 || done_cnt != d0 + 1 || acc_cyc != done_cyc) begin
      errors++;
      $display("FAIL b2b_accept: accepts %0d dones %0d accept_cyc %0d done_cyc %0d want 2 1 equal",
               acc_cnt - c0, done_cnt - d0, acc_cyc, done_cyc);
    end
    dev_frame(11, 1'b1, 1'b1);
    n = 0;
    while (done_cnt < d0 + 2 && n < 200) begin
      wcyc(1);
      n++;
    end
    wcyc(3);
    checks++;
    if (done_cnt != d0 + 2 || acc_cnt != c0 + 2) begin
      errors++;
      $display("FAIL b2b_done: dones %0d accepts %0d want 2 2", done_cnt - d0, acc_cnt - c0);
    end
  endtask

  initial begin
    test_reset();
    test_send(8'hED);
    test_send(8'h00);
    test_ack_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (overlap != 0 || idle_drive != 0) begin
      errors++;
      $display("FAIL invariants: overlapping pulses %0d idle drive cycles %0d want 0 0", overlap, idle_drive);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expected frames never seen", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
